// File: rtl/fpu_pkg.sv
// Shared types, opcodes, latencies and rounding helpers for the single-precision FPU.
package fpu_pkg;

    localparam int unsigned W        = 32;
    localparam int unsigned MAN_W    = 24;
    localparam int unsigned QUO_W    = 27;
    localparam int unsigned DIV_BITS = 3;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned XE_W     = 10;

    localparam logic [3:0] FADD  = 4'd2;
    localparam logic [3:0] FSUB  = 4'd3;
    localparam logic [3:0] FMUL  = 4'd4;
    localparam logic [3:0] FINV  = 4'd5;
    localparam logic [3:0] FDIV  = 4'd6;
    localparam logic [3:0] FHALF = 4'd7;
    localparam logic [3:0] FEQ   = 4'd11;
    localparam logic [3:0] FLE   = 4'd12;
    localparam logic [3:0] FABS  = 4'd13;
    localparam logic [3:0] FNEG  = 4'd14;

    localparam int unsigned LAT_SIMPLE = 1;
    localparam int unsigned LAT_ADD    = 2;
    localparam int unsigned LAT_MUL    = 2;
    localparam int unsigned LAT_DIV    = 10;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] man;
    } f32_t;

    // Initial BUSY counter value (latency - 1) for an opcode.
    function automatic logic [CNT_W-1:0] lat_cnt(input logic [3:0] ctl);
        case (ctl)
            FADD, FSUB: lat_cnt = CNT_W'(LAT_ADD - 1);
            FMUL:       lat_cnt = CNT_W'(LAT_MUL - 1);
            FINV, FDIV: lat_cnt = CNT_W'(LAT_DIV - 1);
            default:    lat_cnt = CNT_W'(LAT_SIMPLE - 1);
        endcase
    endfunction

    // Leading-zero count of a 27-bit value (result unused when v == 0).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    // Round-to-nearest-even a normalized 1.23 mantissa, then flush/saturate the exponent.
    function automatic f32_t round_pack(input logic s, input logic signed [XE_W-1:0] e,
                                        input logic [MAN_W-1:0] m, input logic g,
                                        input logic st);
        logic [MAN_W:0]          r;
        logic signed [XE_W-1:0]  ex;
        r  = {1'b0, m} + (MAN_W+1)'(g & (st | m[0]));
        ex = e;
        if (r[MAN_W]) begin
            r  = r >> 1;
            ex = e + 10'sd1;
        end
        if (ex >= 10'sd255)
            round_pack = {s, 8'hFF, 23'd0};
        else if (ex <= 10'sd0)
            round_pack = {s, 31'd0};
        else
            round_pack = {s, ex[7:0], r[22:0]};
    endfunction

endpackage

// File: rtl/fpu_if.sv
// Request/response bundle between the execute stage and the FPU.
interface fpu_if;
    import fpu_pkg::*;

    logic         en;
    logic [3:0]   ctl;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic [W-1:0] y;
    logic         ready;

    modport master (output en, ctl, x1, x2, input y, ready);
    modport slave  (input en, ctl, x1, x2, output y, ready);
endinterface

// File: rtl/fpu_div.sv
// Iterative restoring mantissa divider producing three quotient bits per step.
module fpu_div
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [MAN_W-1:0] a_man,
    input  logic [MAN_W-1:0] b_man,
    output logic [QUO_W-1:0] quo,
    output logic             rem_nz
);

    logic [MAN_W:0]    rem;
    logic [MAN_W-1:0]  dvs;
    logic [MAN_W:0]    rem_c;
    logic [DIV_BITS-1:0] bits_c;

    // Three unrolled compare/subtract/shift steps; remainder stays below 2*divisor.
    always_comb begin
        rem_c  = rem;
        bits_c = '0;
        for (int i = DIV_BITS - 1; i >= 0; i--) begin
            bits_c[i] = (rem_c >= {1'b0, dvs});
            if (bits_c[i]) rem_c = rem_c - {1'b0, dvs};
            rem_c = rem_c << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            dvs <= '0;
            quo <= '0;
        end else if (start) begin
            rem <= {1'b0, a_man};
            dvs <= b_man;
            quo <= '0;
        end else if (step) begin
            rem <= rem_c;
            quo <= {quo[QUO_W-DIV_BITS-1:0], bits_c};
        end
    end

    assign rem_nz = |rem;

endmodule

// File: rtl/fpu_core.sv
// Single-precision FPU: one op per en pulse, result in y with a one-cycle ready pulse.
module fpu_core
    import fpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    fpu_if.slave bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_ctl;
    f32_t             a;
    f32_t             b;
    logic [W-1:0]     y_q;
    logic             ready_q;
    logic [W-1:0]     result_c;

    assign bus.y     = y_q;
    assign bus.ready = ready_q;

    // Denormal-as-zero classification of the captured operands
    logic        a_zero, b_zero;
    logic [30:0] mag_a, mag_b;
    logic [26:0] ma27, mb27;
    assign a_zero = (a.exp == 8'd0);
    assign b_zero = (b.exp == 8'd0);
    assign mag_a  = a_zero ? 31'd0 : a[30:0];
    assign mag_b  = b_zero ? 31'd0 : b[30:0];
    assign ma27   = a_zero ? 27'd0 : {1'b1, a.man, 3'b000};
    assign mb27   = b_zero ? 27'd0 : {1'b1, b.man, 3'b000};

    logic         eq_c, le_c;
    logic [W-1:0] half_c;
    assign eq_c = (mag_a == mag_b) && ((mag_a == 31'd0) || (a.sign == b.sign));
    assign le_c = eq_c || (a.sign && !b.sign)
               || (!a.sign && !b.sign && (mag_a < mag_b))
               || (a.sign && b.sign && (mag_a > mag_b));
    assign half_c = (a.exp <= 8'd1) ? {a.sign, 31'd0} : {a.sign, a.exp - 8'd1, a.man};

    // Add/sub stage 1: order by magnitude, align the smaller operand with G/R/S bits
    logic        b_sign_eff, a_big, bg_sign, sm_sign, eff_sub, zsign_c;
    logic [7:0]  bg_exp, sm_exp, diff;
    logic [4:0]  dsh;
    logic [26:0] bg27, sm27, al;
    logic [53:0] sh;
    logic [27:0] sum_c;

    always_comb begin
        b_sign_eff = b.sign ^ (op_ctl == FSUB);
        a_big      = (mag_a >= mag_b);
        bg_sign    = a_big ? a.sign : b_sign_eff;
        sm_sign    = a_big ? b_sign_eff : a.sign;
        bg_exp     = a_big ? a.exp : b.exp;
        sm_exp     = a_big ? b.exp : a.exp;
        bg27       = a_big ? ma27 : mb27;
        sm27       = a_big ? mb27 : ma27;
        diff       = bg_exp - sm_exp;
        dsh        = (diff > 8'd27) ? 5'd27 : diff[4:0];
        sh         = {sm27, 27'd0} >> dsh;
        al         = {sh[53:28], sh[27] | (|sh[26:0])};
        eff_sub    = (bg_sign != sm_sign);
        sum_c      = eff_sub ? ({1'b0, bg27} - {1'b0, al}) : ({1'b0, bg27} + {1'b0, al});
        zsign_c    = a_zero & b_zero & a.sign & b_sign_eff;
    end

    logic              ad_sign, ad_zsign;
    logic [7:0]        ad_exp;
    logic [27:0]       ad_sum;
    logic              mu_sign, mu_zero;
    logic signed [XE_W-1:0] mu_e;
    logic [47:0]       mu_p;

    // Stage-1 pipeline registers, free-running off the captured operands
    always_ff @(posedge clk) begin
        ad_sign  <= bg_sign;
        ad_zsign <= zsign_c;
        ad_exp   <= bg_exp;
        ad_sum   <= sum_c;
        mu_sign  <= a.sign ^ b.sign;
        mu_zero  <= a_zero | b_zero;
        mu_e     <= $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - 10'sd127;
        mu_p     <= {1'b1, a.man} * {1'b1, b.man};
    end

    // Add/sub stage 2: normalize and round
    logic [4:0]             ad_lz;
    logic [26:0]            ad_norm;
    logic signed [XE_W-1:0] ad_e;
    logic [W-1:0]           add_res_c;

    always_comb begin
        add_res_c = '0;
        ad_lz     = lzc27(ad_sum[26:0]);
        ad_norm   = ad_sum[26:0] << ad_lz;
        ad_e      = $signed({2'b00, ad_exp});
        if (ad_sum == 28'd0)
            add_res_c = {ad_zsign, 31'd0};
        else if (ad_sum[27])
            add_res_c = round_pack(ad_sign, ad_e + 10'sd1, ad_sum[27:4], ad_sum[3], |ad_sum[2:0]);
        else
            add_res_c = round_pack(ad_sign, ad_e - $signed({5'd0, ad_lz}),
                                   ad_norm[26:3], ad_norm[2], |ad_norm[1:0]);
    end

    logic [W-1:0] mul_res_c;
    always_comb begin
        mul_res_c = '0;
        if (mu_zero)
            mul_res_c = {mu_sign, 31'd0};
        else if (mu_p[47])
            mul_res_c = round_pack(mu_sign, mu_e + 10'sd1, mu_p[47:24], mu_p[23], |mu_p[22:0]);
        else
            mul_res_c = round_pack(mu_sign, mu_e, mu_p[46:23], mu_p[22], |mu_p[21:0]);
    end

    // Divider: finv divides 1.0 by x1; operands load straight from the bus on accept
    logic             dv_start, dv_step, rem_nz;
    logic [MAN_W-1:0] dv_a_in, dv_b_in;
    logic [QUO_W-1:0] quo;

    assign dv_start = (state == IDLE) && bus.en;
    assign dv_step  = (state == BUSY) && (cnt != '0);
    assign dv_a_in  = (bus.ctl == FINV) ? 24'h800000 : {1'b1, bus.x1[22:0]};
    assign dv_b_in  = (bus.ctl == FINV) ? {1'b1, bus.x1[22:0]} : {1'b1, bus.x2[22:0]};

    fpu_div u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (dv_start),
        .step   (dv_step),
        .a_man  (dv_a_in),
        .b_man  (dv_b_in),
        .quo    (quo),
        .rem_nz (rem_nz)
    );

    logic                   dv_inv, dv_sign;
    logic [7:0]             dv_num_exp;
    f32_t                   dv_den;
    logic signed [XE_W-1:0] dv_e;
    logic [W-1:0]           div_res_c;

    always_comb begin
        div_res_c  = '0;
        dv_inv     = (op_ctl == FINV);
        dv_num_exp = dv_inv ? 8'd127 : a.exp;
        dv_den     = dv_inv ? a : b;
        dv_sign    = (dv_inv ? 1'b0 : a.sign) ^ dv_den.sign;
        dv_e       = $signed({2'b00, dv_num_exp}) - $signed({2'b00, dv_den.exp}) + 10'sd127;
        if (dv_den.exp == 8'd0)
            div_res_c = {dv_sign, 8'hFF, 23'd0};
        else if (!dv_inv && a_zero)
            div_res_c = {dv_sign, 31'd0};
        else if (quo[26])
            div_res_c = round_pack(dv_sign, dv_e, quo[26:3], quo[2], (|quo[1:0]) | rem_nz);
        else
            div_res_c = round_pack(dv_sign, dv_e - 10'sd1, quo[25:2], quo[1], quo[0] | rem_nz);
    end

    always_comb begin
        result_c = '0;
        case (op_ctl)
            FADD, FSUB: result_c = add_res_c;
            FMUL:       result_c = mul_res_c;
            FINV, FDIV: result_c = div_res_c;
            FHALF:      result_c = half_c;
            FEQ:        result_c = {31'd0, eq_c};
            FLE:        result_c = {31'd0, le_c};
            FABS:       result_c = {1'b0, a[30:0]};
            FNEG:       result_c = {~a.sign, a[30:0]};
            default:    result_c = '0;
        endcase
    end

    // Control FSM: capture on en, count down the op latency, then publish y
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_ctl  <= '0;
            a       <= '0;
            b       <= '0;
            y_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        op_ctl <= bus.ctl;
                        a      <= bus.x1;
                        b      <= bus.x2;
                        cnt    <= lat_cnt(bus.ctl);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        y_q     <= result_c;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_core.sv
// Directed and integer-exact randomized checks of fpu_core results, latency and control.
module tb_fpu_core;
    import fpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    fpu_if bus ();

    fpu_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Exact int -> binary32 for |v| < 2^24
    function automatic logic [31:0] i2f(input int v);
        logic [31:0] m;
        logic        s;
        int          p;
        if (v == 0) return 32'd0;
        s = (v < 0);
        m = s ? 32'(-v) : 32'(v);
        p = 0;
        for (int k = 0; k < 32; k++) if (m[k]) p = k;
        m = m << (23 - p);
        return {s, 8'(127 + p), m[22:0]};
    endfunction

    function automatic int rnd(input int unsigned lo, input int unsigned hi);
        int v;
        v = int'($urandom_range(hi, lo));
        if ($urandom_range(1, 0) == 1) v = -v;
        return v;
    endfunction

    // Issue one op, scramble the inputs afterwards, and check latency and result.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] xa,
                          input logic [31:0] xb, input logic [31:0] exp_y, input int lat);
        int n;
        bit seen;
        bus.en = 1'b1; bus.ctl = c; bus.x1 = xa; bus.x2 = xb;
        @(posedge clk); #1;
        bus.en = 1'b0; bus.ctl = 4'hF ^ c; bus.x1 = ~xa; bus.x2 = ~xb;
        n = 0; seen = 1'b0;
        while (!seen && n < 12) begin
            @(posedge clk); #1;
            n++;
            if (bus.ready) seen = 1'b1;
        end
        chk({tag, "_lat"}, 32'(seen ? n : 99), 32'(lat));
        chk({tag, "_y"}, bus.y, exp_y);
    endtask

    initial begin
        int pulses, first_edge, sel, ia, ib;
        logic [31:0] yv;

        rst = 1'b1; bus.en = 1'b0; bus.ctl = 4'd0; bus.x1 = '0; bus.x2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_y", bus.y, 32'd0);
        chk("reset_ready", {31'd0, bus.ready}, 32'd0);
        rst = 1'b0;

        run_op("fadd",      FADD,  32'h3F800000, 32'h40000000, 32'h40400000, 2);
        run_op("fsub",      FSUB,  32'h3F800000, 32'h40000000, 32'hBF800000, 2);
        run_op("fmul",      FMUL,  32'h3FC00000, 32'h40000000, 32'h40400000, 2);
        run_op("fhalf",     FHALF, 32'h40400000, 32'h0,        32'h3FC00000, 1);
        run_op("fdiv_3rd",  FDIV,  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 10);
        run_op("finv_4",    FINV,  32'h40800000, 32'h0,        32'h3E800000, 10);
        run_op("feq_zero",  FEQ,   32'h00000000, 32'h80000000, 32'h1,        1);
        run_op("fle_2_1",   FLE,   32'h40000000, 32'h3F800000, 32'h0,        1);
        run_op("fle_m2_1",  FLE,   32'hC0000000, 32'h3F800000, 32'h1,        1);
        run_op("fabs",      FABS,  32'hC0490FDB, 32'h0,        32'h40490FDB, 1);
        run_op("fneg",      FNEG,  32'h40490FDB, 32'h0,        32'hC0490FDB, 1);
        run_op("fadd_canc", FADD,  32'h3F800000, 32'hBF800000, 32'h00000000, 2);
        run_op("fadd_tie",  FADD,  32'h3F800000, 32'h33800000, 32'h3F800000, 2);
        run_op("fadd_rup",  FADD,  32'h3F800000, 32'h34400000, 32'h3F800002, 2);
        run_op("fmul_rnd",  FMUL,  32'h3F800001, 32'h3F800001, 32'h3F800002, 2);
        run_op("fmul_ovf",  FMUL,  32'h7F000000, 32'h40000000, 32'h7F800000, 2);
        run_op("fmul_unf",  FMUL,  32'h00800000, 32'h3F000000, 32'h00000000, 2);
        run_op("fdiv_6_3",  FDIV,  32'h40C00000, 32'h40400000, 32'h40000000, 10);
        run_op("fdiv_dz",   FDIV,  32'hBF800000, 32'h00000000, 32'hFF800000, 10);
        run_op("finv_mz",   FINV,  32'h80000000, 32'h0,        32'hFF800000, 10);
        run_op("fhalf_e1",  FHALF, 32'h80FFFFFF, 32'h0,        32'h80000000, 1);
        run_op("feq_den",   FEQ,   32'h00000001, 32'h00000000, 32'h1,        1);
        run_op("fle_eq",    FLE,   32'h3F800000, 32'h3F800000, 32'h1,        1);
        run_op("fle_negs",  FLE,   32'hC0000000, 32'hBF800000, 32'h1,        1);
        run_op("fle_negr",  FLE,   32'hBF800000, 32'hC0000000, 32'h0,        1);
        run_op("fabs_den",  FABS,  32'h80000001, 32'h0,        32'h00000001, 1);
        run_op("op_0",      4'd0,  32'h3F800000, 32'h3F800000, 32'h0,        1);
        run_op("fneg_pre",  FNEG,  32'h00000000, 32'h0,        32'h80000000, 1);
        run_op("op_15",     4'd15, 32'h3F800000, 32'h3F800000, 32'h0,        1);

        // Second en while a divide is in flight must be ignored
        bus.en = 1'b1; bus.ctl = FDIV; bus.x1 = 32'h3F800000; bus.x2 = 32'h40400000;
        @(posedge clk); #1;
        bus.en = 1'b0;
        pulses = 0; first_edge = 0; yv = '0;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) begin
                bus.en = 1'b1; bus.ctl = FADD; bus.x1 = 32'h3F800000; bus.x2 = 32'h3F800000;
            end
            if (k == 4) bus.en = 1'b0;
            @(posedge clk); #1;
            if (bus.ready) begin
                pulses++;
                if (pulses == 1) begin
                    first_edge = k + 1;
                    yv = bus.y;
                end
            end
        end
        chk("busy_pulses", 32'(pulses), 32'd1);
        chk("busy_lat", 32'(first_edge), 32'd10);
        chk("busy_y", yv, 32'h3EAAAAAB);

        // Reset four edges into a divide discards it
        bus.en = 1'b1; bus.ctl = FDIV; bus.x1 = 32'h40C00000; bus.x2 = 32'h40400000;
        @(posedge clk); #1;
        bus.en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_y", bus.y, 32'd0);
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.ready) pulses++;
        end
        chk("rst_no_ready", 32'(pulses), 32'd0);
        run_op("post_rst", FADD, 32'h40000000, 32'h40000000, 32'h40800000, 2);

        // Randomized integer-valued operands whose results are exactly representable
        for (int i = 0; i < 50; i++) begin
            sel = int'($urandom_range(5, 0));
            case (sel)
                0: begin
                    ia = rnd(0, 1 << 20); ib = rnd(0, 1 << 20);
                    run_op("rnd_fadd", FADD, i2f(ia), i2f(ib), i2f(ia + ib), 2);
                end
                1: begin
                    ia = rnd(0, 1 << 20); ib = rnd(0, 1 << 20);
                    run_op("rnd_fsub", FSUB, i2f(ia), i2f(ib), i2f(ia - ib), 2);
                end
                2: begin
                    ia = rnd(1, 2047); ib = rnd(1, 2047);
                    run_op("rnd_fmul", FMUL, i2f(ia), i2f(ib), i2f(ia * ib), 2);
                end
                3: begin
                    ia = rnd(1, 2047); ib = rnd(1, 2047);
                    run_op("rnd_fdiv", FDIV, i2f(ia * ib), i2f(ib), i2f(ia), 10);
                end
                4: begin
                    ia = rnd(0, 8); ib = rnd(0, 8);
                    run_op("rnd_fle", FLE, i2f(ia), i2f(ib), 32'(ia <= ib), 1);
                end
                default: begin
                    ia = rnd(0, 4); ib = rnd(0, 4);
                    run_op("rnd_feq", FEQ, i2f(ia), i2f(ib), 32'(ia == ib), 1);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
